// File: rtl/ov7670_config_sequencer.sv
// ---------------------------------------------------------------------------
// ov7670_config_sequencer
//
// Purpose:
//   Walks the OV7670 configuration ROM from address 0 and turns every
//   {reg_addr, reg_data} word into one SCCB register-write request. The run
//   stops at the end-marker word, or after the entry at the last ROM address.
//   After the COM7 soft-reset entry completes, the sequencer stalls for a
//   fixed settle time before the next fetch. NACKed writes are re-issued a
//   bounded number of times before the run ends in an error.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   start_i          single-cycle start pulse (ignored while busy)
//   rom_addr_o       ROM read address (ROM answers one clock later)
//   rom_data_i       ROM word {reg_addr[15:8], reg_data[7:0]}
//   sccb_valid_o     write request valid
//   sccb_ready_i     SCCB master accepts the request this cycle
//   sccb_reg_addr_o  register address of the request
//   sccb_reg_data_o  register data of the request
//   sccb_done_i      one-cycle pulse: accepted transaction finished
//   sccb_nack_i      qualified by sccb_done_i: slave did not acknowledge
//   busy_o           sequence in progress
//   done_o           sequence completed (held until next start or reset)
//   error_o          retries exhausted (held until next start or reset)
//   write_count_o    successfully completed writes in this run
// ---------------------------------------------------------------------------
module ov7670_config_sequencer #(
  parameter int          ADDR_W            = 8,
  parameter logic [15:0] END_MARKER        = 16'hFFFF,
  parameter logic [15:0] RESET_WORD        = 16'h1280,
  parameter int          RESET_WAIT_CYCLES = 1_000_000,
  parameter int          MAX_RETRIES       = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              sccb_valid_o,
  input  logic              sccb_ready_i,
  output logic [7:0]        sccb_reg_addr_o,
  output logic [7:0]        sccb_reg_data_o,
  input  logic              sccb_done_i,
  input  logic              sccb_nack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] write_count_o
);

  // The delay counter only has to hold RESET_WAIT_CYCLES-1, the retry
  // counter has to reach MAX_RETRIES.
  localparam int DLY_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    DONE,
    ERROR
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_W-1:0] r_romAddr;
  logic [ADDR_W-1:0] r_writeCount;
  logic [RTY_W-1:0]  r_retry;
  logic [DLY_W-1:0]  r_delayCnt;
  logic [7:0]        r_regAddr;
  logic [7:0]        r_regData;
  logic              r_valid;
  logic              r_done;
  logic              r_error;
  logic              w_busy;

  logic w_isLastAddr;
  logic w_isEndMarker;
  logic w_isResetWord;
  logic w_retryLeft;
  logic w_delayZero;
  logic w_canStart;

  assign w_isLastAddr  = (r_romAddr == '1);
  assign w_isEndMarker = (rom_data_i == END_MARKER);
  // The settle delay keys off the entry that was just written, which is
  // still held in the request registers while waiting for completion.
  assign w_isResetWord = ({r_regAddr, r_regData} == RESET_WORD);
  assign w_retryLeft   = (r_retry < RTY_MAX);
  assign w_delayZero   = (r_delayCnt == '0);
  assign w_canStart    = start_i && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

  // State register: the only place the FSM state changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The end-of-entry decision is shared between the
  // plain completion path and the end of the settle delay: the last ROM
  // address finishes the run instead of wrapping.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (start_i) w_nextState = FETCH;
      end
      FETCH: w_nextState = DECODE;
      DECODE: begin
        w_nextState = w_isEndMarker ? DONE : ISSUE;
      end
      ISSUE: begin
        if (sccb_ready_i) w_nextState = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sccb_done_i) begin
          if (!sccb_nack_i) begin
            if (w_isResetWord)     w_nextState = DELAY;
            else if (w_isLastAddr) w_nextState = DONE;
            else                   w_nextState = FETCH;
          end else begin
            w_nextState = w_retryLeft ? ISSUE : ERROR;
          end
        end
      end
      DELAY: begin
        if (w_delayZero) w_nextState = w_isLastAddr ? DONE : FETCH;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: busy covers every state that is part of an active run.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: w_busy = 1'b0;
      default:           w_busy = 1'b1;
    endcase
  end

  // Datapath registers. They follow the same decisions as the next-state
  // logic so that addresses, counters and the request are updated on the
  // same edge as the state change they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_romAddr    <= '0;
      r_writeCount <= '0;
      r_retry      <= '0;
      r_delayCnt   <= '0;
      r_regAddr    <= '0;
      r_regData    <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_canStart) begin
            r_romAddr    <= '0;
            r_writeCount <= '0;
            r_retry      <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_valid      <= 1'b0;
          end
        end
        DECODE: begin
          if (w_isEndMarker) begin
            r_done <= 1'b1;
          end else begin
            r_regAddr <= rom_data_i[15:8];
            r_regData <= rom_data_i[7:0];
            r_valid   <= 1'b1;
          end
        end
        ISSUE: begin
          if (sccb_ready_i) r_valid <= 1'b0;
        end
        WAIT_DONE: begin
          if (sccb_done_i) begin
            if (!sccb_nack_i) begin
              r_writeCount <= r_writeCount + ADDR_W'(1);
              r_retry      <= '0;
              if (w_isResetWord)     r_delayCnt <= DLY_LOAD;
              else if (w_isLastAddr) r_done     <= 1'b1;
              else                   r_romAddr  <= r_romAddr + ADDR_W'(1);
            end else if (w_retryLeft) begin
              // Same entry is still in the request registers.
              r_retry <= r_retry + RTY_W'(1);
              r_valid <= 1'b1;
            end else begin
              // The failing address stays on rom_addr_o for diagnosis.
              r_error <= 1'b1;
            end
          end
        end
        DELAY: begin
          if (w_delayZero) begin
            if (w_isLastAddr) r_done    <= 1'b1;
            else              r_romAddr <= r_romAddr + ADDR_W'(1);
          end else begin
            r_delayCnt <= r_delayCnt - DLY_W'(1);
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o      = r_romAddr;
  assign sccb_valid_o    = r_valid;
  assign sccb_reg_addr_o = r_regAddr;
  assign sccb_reg_data_o = r_regData;
  assign busy_o          = w_busy;
  assign done_o          = r_done;
  assign error_o         = r_error;
  assign write_count_o   = r_writeCount;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ov7670_config_sequencer
//
// Purpose:
//   Directed self-checking bench for ov7670_config_sequencer. A registered
//   ROM model and a small SCCB slave model (programmable backpressure and
//   NACK) surround the DUT; the main process runs the directed scenarios.
//   Small parameters are used (ADDR_W=3, 20 settle cycles, 2 retries) so the
//   last-address boundary and the settle delay are reachable quickly.
// ---------------------------------------------------------------------------
module tb_ov7670_config_sequencer;

  localparam int ADDR_W = 3;
  localparam int WAIT_C = 20;
  localparam int RETRY  = 2;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [15:0]       rom_data_i = 16'h0000;
  logic              sccb_valid_o;
  logic              sccb_ready_i = 1'b0;
  logic [7:0]        sccb_reg_addr_o;
  logic [7:0]        sccb_reg_data_o;
  logic              sccb_done_i = 1'b0;
  logic              sccb_nack_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic              error_o;
  logic [ADDR_W-1:0] write_count_o;

  ov7670_config_sequencer #(
    .ADDR_W(ADDR_W),
    .END_MARKER(16'hFFFF),
    .RESET_WORD(16'h1280),
    .RESET_WAIT_CYCLES(WAIT_C),
    .MAX_RETRIES(RETRY)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i),
    .sccb_valid_o(sccb_valid_o),
    .sccb_ready_i(sccb_ready_i),
    .sccb_reg_addr_o(sccb_reg_addr_o),
    .sccb_reg_data_o(sccb_reg_data_o),
    .sccb_done_i(sccb_done_i),
    .sccb_nack_i(sccb_nack_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .write_count_o(write_count_o)
  );

  always #5 clk = ~clk;

  int compareCount = 0;
  int mismatchCount = 0;
  int cyc = 0;

  logic [15:0] rom [0:7];

  // Slave model state, written only by the slave process.
  logic [15:0] xferLog [$];
  int          riseCyc [$];
  int          doneCyc [$];
  int          pending = 0;
  logic        nackNext = 1'b0;
  logic        prevValid = 1'b0;
  int          stallSeen = 0;

  // Slave configuration, written only by the main process.
  logic        nackEnable = 1'b0;
  logic [7:0]  nackRegAddr = 8'h00;
  int          stallLeft = 0;
  logic [15:0] stallExpect = 16'h0000;
  int          stallLeftSlave = 0;
  int          stallReq = 0;

  int          startCyc = 0;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM: data for an address appears one clock after it is driven.
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // SCCB slave model. Acts on the falling edge so every value it drives is
  // settled before the DUT samples it. Ready is decided first, so a
  // transfer is logged exactly when the coming rising edge will accept it.
  // Completion is signalled four clocks after acceptance.
  always @(negedge clk) begin
    sccb_done_i = 1'b0;
    sccb_nack_i = 1'b0;
    if (stallReq != 0) begin
      stallLeftSlave = stallReq;
    end
    if (!rst_ni) begin
      pending = 0;
      prevValid = 1'b0;
      sccb_ready_i = 1'b1;
    end else begin
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          sccb_done_i = 1'b1;
          sccb_nack_i = nackNext;
          doneCyc.push_back(cyc);
        end
      end
      if (sccb_valid_o && !prevValid) riseCyc.push_back(cyc);
      prevValid = sccb_valid_o;
      if (sccb_valid_o && stallLeftSlave > 0) begin
        checkOutput("stall_hold", {sccb_reg_addr_o, sccb_reg_data_o}, stallExpect);
        stallLeftSlave--;
        stallSeen++;
      end
      sccb_ready_i = (stallLeftSlave == 0);
      if (sccb_valid_o && sccb_ready_i) begin
        xferLog.push_back({sccb_reg_addr_o, sccb_reg_data_o});
        pending = 4;
        nackNext = nackEnable && (sccb_reg_addr_o == nackRegAddr);
      end
    end
  end

  // One-cycle start pulse, driven on the falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    start_i = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic fillRom(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
    rom[3] = w3;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (!(done_o || error_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_finished"}, 32'(done_o || error_o), 32'd1);
    checkOutput({tag, "_exclusive"}, 32'(done_o && error_o), 32'd0);
  endtask

  task automatic waitXfers(input string tag, input int target);
    int n;
    n = 0;
    while (xferLog.size() < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_reached"}, 32'(xferLog.size() >= target), 32'd1);
  endtask

  initial begin
    int base;
    int rbase;
    int dbase;
    int attempts;

    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    $display("[TB] starting ov7670_config_sequencer bench");

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", sccb_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_error", error_o, 0);
    checkOutput("rst_count", write_count_o, 0);
    checkOutput("rst_addr", rom_addr_o, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // 1) Plain three-entry sequence.
    fillRom(16'h1204, 16'h1180, 16'h3A04, 16'hFFFF);
    base = xferLog.size();
    rbase = riseCyc.size();
    applyStimulus();
    checkOutput("t1_busy", busy_o, 1);
    waitIdle("t1");
    checkOutput("t1_nxfer", xferLog.size() - base, 3);
    checkOutput("t1_x0", xferLog[base], 16'h1204);
    checkOutput("t1_x1", xferLog[base+1], 16'h1180);
    checkOutput("t1_x2", xferLog[base+2], 16'h3A04);
    checkOutput("t1_count", write_count_o, 3);
    checkOutput("t1_done", done_o, 1);
    checkOutput("t1_busy_end", busy_o, 0);
    checkOutput("t1_error", error_o, 0);
    // Start sampled on one edge, FETCH, DECODE, valid after the third edge.
    checkOutput("t1_latency", riseCyc[rbase] - startCyc, 3);

    // 2) Soft-reset entry followed by the settle delay.
    fillRom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    base = xferLog.size();
    rbase = riseCyc.size();
    dbase = doneCyc.size();
    applyStimulus();
    waitIdle("t2");
    checkOutput("t2_nxfer", xferLog.size() - base, 2);
    checkOutput("t2_x0", xferLog[base], 16'h1280);
    checkOutput("t2_x1", xferLog[base+1], 16'h1204);
    checkOutput("t2_count", write_count_o, 2);
    checkOutput("t2_done", done_o, 1);
    // Done seen, 20 DELAY cycles, FETCH, DECODE, then valid: 23 clocks.
    checkOutput("t2_settle", riseCyc[rbase+1] - doneCyc[dbase], WAIT_C + 3);

    // 3) Backpressure on the first request.
    fillRom(16'h1204, 16'h1180, 16'h3A04, 16'hFFFF);
    base = xferLog.size();
    stallExpect = 16'h1204;
    stallSeen = 0;
    stallReq = 5;
    @(negedge clk);
    stallReq = 0;
    applyStimulus();
    waitIdle("t3");
    checkOutput("t3_stall_cycles", stallSeen, 5);
    checkOutput("t3_nxfer", xferLog.size() - base, 3);
    checkOutput("t3_x0", xferLog[base], 16'h1204);
    checkOutput("t3_count", write_count_o, 3);

    // 4) Entry 1 is NACKed on every attempt.
    nackEnable = 1'b1;
    nackRegAddr = 8'h11;
    base = xferLog.size();
    applyStimulus();
    waitIdle("t4");
    attempts = 0;
    for (int i = base; i < xferLog.size(); i++) begin
      if (xferLog[i] == 16'h1180) attempts++;
    end
    checkOutput("t4_attempts", attempts, RETRY + 1);
    checkOutput("t4_nxfer", xferLog.size() - base, RETRY + 2);
    checkOutput("t4_error", error_o, 1);
    checkOutput("t4_done", done_o, 0);
    checkOutput("t4_addr", rom_addr_o, 1);
    checkOutput("t4_count", write_count_o, 1);
    checkOutput("t4_busy", busy_o, 0);
    nackEnable = 1'b0;

    // 5) Reset while waiting for the second write to complete.
    base = xferLog.size();
    applyStimulus();
    checkOutput("t5_error_cleared", error_o, 0);
    waitXfers("t5_second", base + 2);
    @(negedge clk);
    checkOutput("t5_pre_busy", busy_o, 1);
    checkOutput("t5_pre_count", write_count_o, 1);
    checkOutput("t5_pre_addr", rom_addr_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("t5_rst_valid", sccb_valid_o, 0);
    checkOutput("t5_rst_busy", busy_o, 0);
    checkOutput("t5_rst_count", write_count_o, 0);
    checkOutput("t5_rst_addr", rom_addr_o, 0);
    checkOutput("t5_rst_req", {sccb_reg_addr_o, sccb_reg_data_o}, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t5_stays_idle", xferLog.size() - base, 2);
    checkOutput("t5_idle_busy", busy_o, 0);
    base = xferLog.size();
    applyStimulus();
    waitIdle("t5");
    checkOutput("t5_nxfer", xferLog.size() - base, 3);
    checkOutput("t5_x0", xferLog[base], 16'h1204);
    checkOutput("t5_count", write_count_o, 3);

    // 6a) Start pulsed mid-run is ignored.
    base = xferLog.size();
    applyStimulus();
    waitXfers("t6_mid", base + 2);
    applyStimulus();
    waitIdle("t6a");
    checkOutput("t6_nxfer", xferLog.size() - base, 3);
    checkOutput("t6_x2", xferLog[base+2], 16'h3A04);
    checkOutput("t6_count", write_count_o, 3);

    // 6b) End marker at address 0.
    fillRom(16'hFFFF, 16'h1204, 16'hFFFF, 16'hFFFF);
    base = xferLog.size();
    rbase = riseCyc.size();
    applyStimulus();
    waitIdle("t6b");
    checkOutput("t6b_done", done_o, 1);
    checkOutput("t6b_count", write_count_o, 0);
    checkOutput("t6b_nxfer", xferLog.size() - base, 0);
    checkOutput("t6b_nvalid", riseCyc.size() - rbase, 0);
    checkOutput("t6b_busy", busy_o, 0);

    // 7) No end marker: last address is issued, then the run ends.
    for (int i = 0; i < 8; i++) rom[i] = {8'h20 + 8'(i), 8'h10 + 8'(i)};
    base = xferLog.size();
    applyStimulus();
    waitIdle("t7");
    checkOutput("t7_nxfer", xferLog.size() - base, 8);
    checkOutput("t7_last", xferLog[base+7], 16'h2717);
    checkOutput("t7_addr", rom_addr_o, 7);
    checkOutput("t7_done", done_o, 1);
    repeat (20) @(negedge clk);
    checkOutput("t7_no_wrap", xferLog.size() - base, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
